uart_rx_param: RTL

- Parametrised successor to the fixed 8-bit serial receiver.
- Oversampled UART receiver with:
  - 2-flop input synchronizer
  - mid-bit sampling and false-start rejection
  - configurable data width, parity and stop bits
  - valid/ready holding-register handshake with error flags
- Sits between the pad-side rx line and the register/FIFO front-end. The bclk tick is OVERSAMPLE x baud.

---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_rx_sync.sv | 19 +
 rtl/uart_rx_param.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM states, parity modes and
// the legal parameter envelope.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK_WAIT
  } rx_state_e;

  localparam bit PAR_EVEN = 1'b0;
  localparam bit PAR_ODD  = 1'b1;

  localparam int DATA_BITS_MIN  = 5;
  localparam int DATA_BITS_MAX  = 9;
  localparam int OVERSAMPLE_MIN = 4;
  localparam int OVERSAMPLE_MAX = 16;
  localparam int STOP_BITS_MIN  = 1;
  localparam int STOP_BITS_MAX  = 2;

  function automatic bit cfg_legal(input int db, input int os, input int sb);
    return (db >= DATA_BITS_MIN) && (db <= DATA_BITS_MAX) &&
           (os >= OVERSAMPLE_MIN) && (os <= OVERSAMPLE_MAX) && ((os % 2) == 0) &&
           (sb >= STOP_BITS_MIN) && (sb <= STOP_BITS_MAX);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an idle-high serial line; resets to 1 so a reset
// never looks like a start bit.
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk) begin
    if (!rst_n) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], d_i};
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/uart_rx_param.sv
// Oversampled UART receiver: mid-bit sampling, false-start rejection,
// configurable framing and a valid/ready holding register with error flags.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 4,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 bclk,
  input  logic                 reset,
  input  logic                 rx_data,
  output logic [DATA_BITS-1:0] rhr_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  if (!cfg_legal(DATA_BITS, OVERSAMPLE, STOP_BITS)) begin : g_bad_cfg
    $error("uart_rx_param: illegal DATA_BITS/OVERSAMPLE/STOP_BITS combination");
  end

  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam int BIT_W  = $clog2(DATA_BITS + 1);

  localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);
  localparam bit                PAR_MODE  = (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;

  logic rx_s;

  uart_rx_sync u_sync (
    .clk   (bclk),
    .rst_n (reset),
    .d_i   (rx_data),
    .q_o   (rx_s)
  );

  rx_state_e            state_q;
  logic [TICK_W-1:0]    tick_q;
  logic [BIT_W-1:0]     bit_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] rhr_q;
  logic                 valid_q, perr_q, ferr_q, ovr_q, busy_q;
  // Per-frame accumulators; only copied to the outputs on completion.
  logic                 fperr_q, fferr_q, brk_q;

  logic done_d, hs_d, fferr_d, brk_d;

  always_comb begin
    fferr_d = fferr_q | ~rx_s;
    brk_d   = brk_q & ~rx_s;
    hs_d    = valid_q & rx_ready;
    done_d  = (state_q == STOP) && (tick_q == TICK_LAST) && (bit_q == STOP_LAST);
  end

  always_ff @(posedge bclk) begin
    if (!reset) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      rhr_q   <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
      fperr_q <= 1'b0;
      fferr_q <= 1'b0;
      brk_q   <= 1'b0;
    end else begin
      if (hs_d) begin
        valid_q <= 1'b0;
        perr_q  <= 1'b0;
        ferr_q  <= 1'b0;
        ovr_q   <= 1'b0;
      end
      // A completion on the handshake cycle overrides the clear above.
      if (done_d) begin
        if (!valid_q || rx_ready) begin
          rhr_q   <= shift_q;
          perr_q  <= fperr_q;
          ferr_q  <= fferr_d;
          valid_q <= 1'b1;
        end else begin
          ovr_q <= 1'b1;
        end
      end

      case (state_q)
        IDLE: begin
          if (!rx_s) begin
            state_q <= START;
            tick_q  <= '0;
            busy_q  <= 1'b1;
          end
        end
        START: begin
          if (tick_q == TICK_MID) begin
            tick_q  <= '0;
            bit_q   <= '0;
            fperr_q <= 1'b0;
            fferr_q <= 1'b0;
            brk_q   <= 1'b1;
            if (rx_s) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= DATA;
            end
          end else begin
            tick_q <= tick_q + TICK_W'(1);
          end
        end
        DATA: begin
          if (tick_q == TICK_LAST) begin
            tick_q  <= '0;
            shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
            brk_q   <= brk_d;
            if (bit_q == BIT_LAST) begin
              bit_q   <= '0;
              state_q <= (PARITY_EN != 0) ? PARITY : STOP;
            end else begin
              bit_q <= bit_q + BIT_W'(1);
            end
          end else begin
            tick_q <= tick_q + TICK_W'(1);
          end
        end
        PARITY: begin
          if (tick_q == TICK_LAST) begin
            tick_q  <= '0;
            fperr_q <= ((^shift_q) ^ rx_s) != PAR_MODE;
            state_q <= STOP;
          end else begin
            tick_q <= tick_q + TICK_W'(1);
          end
        end
        STOP: begin
          if (tick_q == TICK_LAST) begin
            tick_q  <= '0;
            fferr_q <= fferr_d;
            brk_q   <= brk_d;
            if (bit_q == STOP_LAST) begin
              bit_q <= '0;
              if (brk_d) begin
                state_q <= BREAK_WAIT;
              end else begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
              end
            end else begin
              bit_q <= bit_q + BIT_W'(1);
            end
          end else begin
            tick_q <= tick_q + TICK_W'(1);
          end
        end
        BREAK_WAIT: begin
          if (rx_s) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign rhr_data   = rhr_q;
  assign rx_valid   = valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign overrun    = ovr_q;
  assign busy       = busy_q;

endmodule
